// File: rtl/sudoku_pkg.sv
// Shared types, seven-segment glyphs and the hex-digit decoder for the sudoku status monitor.
// No latency: declarations and pure functions only.
// No backpressure: nothing here holds state.
package sudoku_pkg;

    typedef enum logic [1:0] {
        VIEW_ROW = 2'd0,
        VIEW_COL = 2'd1,
        VIEW_BLK = 2'd2
    } view_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SUCCESS = 2'd2,
        ST_FAILURE = 2'd3
    } status_e;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronise and debounce one raw active-low push button, emitting a one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before the level/pulse changes.
// No backpressure: free-running, the press pulse is a single cycle and must be consumed at once.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);
    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic            pulse_q, pulse_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            sync_pressed;

    // Debounce counter: accept the new level only after it has differed for the full window
    always_comb begin
        sync1_d      = key_n;
        sync2_d      = sync1_q;
        sync_pressed = ~sync2_q;
        db_d         = db_q;
        cnt_d        = '0;
        pulse_d      = 1'b0;
        if (sync_pressed != db_q) begin
            if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                db_d    = sync_pressed;
                pulse_d = sync_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and debounced state; reset parks the key in the released level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed     = db_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/sudoku_monitor.sv
// Board status/debug monitor: solver status FSM, elapsed-seconds timer, debounced cursor/view keys, 7-seg and LED drive.
// Latency: all outputs registered; one cycle after the causing input/state change (keys add debounce delay).
// No backpressure: inputs are sampled every cycle; key presses are single-cycle events.
module sudoku_monitor
    import sudoku_pkg::*;
#(
    parameter int ORDER           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICKS_PER_SEC   = 50000000,
    localparam int LEN            = ORDER * ORDER,
    localparam int CW             = $clog2(LEN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_cursor_n,
    input  logic          key_view_n,
    input  logic          started,
    input  logic          done_success,
    input  logic          done_failure,
    input  logic [CW-1:0] cursor_row,
    input  logic [CW-1:0] cursor_col,
    input  logic [LEN-1:0] occ_row,
    input  logic [LEN-1:0] occ_col,
    input  logic [LEN-1:0] occ_blk,
    output logic [LEN-1:0] leds,
    output logic [1:0]    view_mode,
    output logic [6:0]    hex_status,
    output logic [20:0]   hex_sec,
    output logic [6:0]    hex_row,
    output logic [6:0]    hex_col
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic cursor_press, view_press;
    logic cursor_level_unused, view_level_unused;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cursor (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_cursor_n),
        .pressed     (cursor_level_unused),
        .press_pulse (cursor_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_view (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_view_n),
        .pressed     (view_level_unused),
        .press_pulse (view_press)
    );

    status_e        state_q, state_d;
    logic [6:0]     hex_status_q, hex_status_d;
    view_mode_e     view_q, view_d;
    logic [LEN-1:0] leds_q, leds_d;
    logic [CW-1:0]  row_q, row_d, col_q, col_d;
    logic [6:0]     hex_row_q, hex_row_d, hex_col_q, hex_col_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [11:0]    sec_q, sec_d;
    logic [20:0]    hex_sec_q, hex_sec_d;
    logic [3:0]     row_nib, col_nib;

    // Status FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Status FSM next state; success beats failure when both arrive together
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (started) state_d = ST_RUN;
            ST_RUN: begin
                if (done_success)      state_d = ST_SUCCESS;
                else if (done_failure) state_d = ST_FAILURE;
            end
            default: if (started) state_d = ST_RUN;
        endcase
    end

    // Status FSM output: glyph of the state being entered so it shows the cycle after the transition
    always_comb begin
        case (state_d)
            ST_RUN:     hex_status_d = SEG_DASH;
            ST_SUCCESS: hex_status_d = SEG_S;
            ST_FAILURE: hex_status_d = SEG_F;
            default:    hex_status_d = SEG_BLANK;
        endcase
    end

    // Elapsed timer: clears on (re)start, counts BCD seconds in RUN, saturates at 999, zero in IDLE
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (state_q == ST_IDLE && state_d == ST_IDLE) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (started && state_d == ST_RUN) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
                presc_d = '0;
                if (sec_q != 12'h999) begin
                    if (sec_q[3:0] != 4'd9) begin
                        sec_d[3:0] = sec_q[3:0] + 4'd1;
                    end else begin
                        sec_d[3:0] = 4'd0;
                        if (sec_q[7:4] != 4'd9) begin
                            sec_d[7:4] = sec_q[7:4] + 4'd1;
                        end else begin
                            sec_d[7:4]  = 4'd0;
                            sec_d[11:8] = sec_q[11:8] + 4'd1;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        hex_sec_d = {hex_to_seg(sec_q[11:8]), hex_to_seg(sec_q[7:4]), hex_to_seg(sec_q[3:0])};
    end

    // Cursor latch, view-mode stepping, LED mask select and hex cursor glyphs
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (cursor_press) begin
            row_d = cursor_row;
            col_d = cursor_col;
        end
        view_d = view_q;
        if (view_press) begin
            case (view_q)
                VIEW_ROW: view_d = VIEW_COL;
                VIEW_COL: view_d = VIEW_BLK;
                default:  view_d = VIEW_ROW;
            endcase
        end
        case (view_q)
            VIEW_ROW: leds_d = occ_row;
            VIEW_COL: leds_d = occ_col;
            default:  leds_d = occ_blk;
        endcase
        row_nib         = '0;
        col_nib         = '0;
        row_nib[CW-1:0] = row_q;
        col_nib[CW-1:0] = col_q;
        hex_row_d       = hex_to_seg(row_nib);
        hex_col_d       = hex_to_seg(col_nib);
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_status_q <= SEG_BLANK;
            presc_q      <= '0;
            sec_q        <= '0;
            hex_sec_q    <= {SEG_ZERO, SEG_ZERO, SEG_ZERO};
            view_q       <= VIEW_ROW;
            leds_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            hex_row_q    <= SEG_ZERO;
            hex_col_q    <= SEG_ZERO;
        end else begin
            hex_status_q <= hex_status_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            hex_sec_q    <= hex_sec_d;
            view_q       <= view_d;
            leds_q       <= leds_d;
            row_q        <= row_d;
            col_q        <= col_d;
            hex_row_q    <= hex_row_d;
            hex_col_q    <= hex_col_d;
        end
    end

    assign leds       = leds_q;
    assign view_mode  = view_q;
    assign hex_status = hex_status_q;
    assign hex_sec    = hex_sec_q;
    assign hex_row    = hex_row_q;
    assign hex_col    = hex_col_q;

endmodule

// File: tb/tb_sudoku_monitor.sv
// Directed bench for sudoku_monitor: keys, cursor latch, status FSM and timer.
// Two instances: normal prescaler (10) and a 1-tick prescaler for saturation.
// Inputs driven 1 ns after the rising edge, outputs sampled at the same point.
module tb_sudoku_monitor;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GS = 7'b0010010;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GB = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_cursor_n, key_view_n;
    logic       started, done_success, done_failure, started_f;
    logic [3:0] cursor_row, cursor_col;
    logic [8:0] occ_row, occ_col, occ_blk;

    logic [8:0]  leds, leds_f;
    logic [1:0]  view_mode, view_mode_f;
    logic [6:0]  hex_status, hex_status_f, hex_row, hex_row_f, hex_col, hex_col_f;
    logic [20:0] hex_sec, hex_sec_f;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sudoku_monitor #(.ORDER(3), .DEBOUNCE_CYCLES(4), .TICKS_PER_SEC(10)) u_dut (
        .clock(clock), .reset(reset), .key_cursor_n(key_cursor_n), .key_view_n(key_view_n),
        .started(started), .done_success(done_success), .done_failure(done_failure),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .occ_row(occ_row), .occ_col(occ_col), .occ_blk(occ_blk),
        .leds(leds), .view_mode(view_mode), .hex_status(hex_status), .hex_sec(hex_sec),
        .hex_row(hex_row), .hex_col(hex_col)
    );

    sudoku_monitor #(.ORDER(3), .DEBOUNCE_CYCLES(4), .TICKS_PER_SEC(1)) u_fast (
        .clock(clock), .reset(reset), .key_cursor_n(1'b1), .key_view_n(1'b1),
        .started(started_f), .done_success(1'b0), .done_failure(1'b0),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .occ_row(occ_row), .occ_col(occ_col), .occ_blk(occ_blk),
        .leds(leds_f), .view_mode(view_mode_f), .hex_status(hex_status_f), .hex_sec(hex_sec_f),
        .hex_row(hex_row_f), .hex_col(hex_col_f)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press_view(input int low_cycles);
        key_view_n = 1'b0;
        step(low_cycles);
        key_view_n = 1'b1;
        step(12);
    endtask

    initial begin
        reset = 1'b1; key_cursor_n = 1'b1; key_view_n = 1'b1;
        started = 1'b0; done_success = 1'b0; done_failure = 1'b0; started_f = 1'b0;
        cursor_row = 4'd0; cursor_col = 4'd0;
        occ_row = 9'h0A5; occ_col = 9'h13C; occ_blk = 9'h1F0;
        step(2);

        // 1. reset values
        chk("rst_view", 32'(view_mode), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_status", 32'(hex_status), 32'(GB));
        chk("rst_sec", 32'(hex_sec), 32'({G0, G0, G0}));
        chk("rst_row", 32'(hex_row), 32'(G0));
        chk("rst_col", 32'(hex_col), 32'(G0));
        reset = 1'b0;
        step(2);
        chk("leds_row", 32'(leds), 32'h0A5);

        // 2. view key: short glitch ignored, then real presses
        press_view(3);
        chk("view_glitch", 32'(view_mode), 32'd0);
        press_view(10);
        chk("view_col", 32'(view_mode), 32'd1);
        chk("leds_col", 32'(leds), 32'h13C);
        press_view(10);
        chk("view_blk", 32'(view_mode), 32'd2);
        chk("leds_blk", 32'(leds), 32'h1F0);
        press_view(10);
        chk("view_wrap", 32'(view_mode), 32'd0);
        press_view(10);
        chk("view_col2", 32'(view_mode), 32'd1);

        // 3. cursor latch
        cursor_row = 4'd5; cursor_col = 4'd8;
        key_cursor_n = 1'b0;
        step(10);
        key_cursor_n = 1'b1;
        step(4);
        chk("hex_row", 32'(hex_row), 32'(G5));
        chk("hex_col", 32'(hex_col), 32'(G8));
        cursor_row = 4'd1; cursor_col = 4'd2;
        step(8);
        chk("hex_row_hold", 32'(hex_row), 32'(G5));
        chk("hex_col_hold", 32'(hex_col), 32'(G8));

        // 4. run 25 cycles, then simultaneous success/failure
        started = 1'b1; step(1); started = 1'b0;
        step(24);
        chk("sec_002", 32'(hex_sec), 32'({G0, G0, G2}));
        chk("status_run", 32'(hex_status), 32'(GD));
        done_success = 1'b1; done_failure = 1'b1;
        step(1);
        done_success = 1'b0; done_failure = 1'b0;
        step(1);
        chk("status_s", 32'(hex_status), 32'(GS));
        step(30);
        chk("sec_frozen", 32'(hex_sec), 32'({G0, G0, G2}));
        chk("status_s_hold", 32'(hex_status), 32'(GS));

        // 5. one-tick prescaler saturates at 999
        started_f = 1'b1; step(1); started_f = 1'b0;
        step(500);
        chk("fast_499", 32'(hex_sec_f), 32'({G4, G9, G9}));
        step(700);
        chk("fast_999", 32'(hex_sec_f), 32'({G9, G9, G9}));
        chk("fast_run", 32'(hex_status_f), 32'(GD));

        // 6. success -> run -> failure -> restart -> reset
        started = 1'b1; step(1); started = 1'b0;
        step(3);
        done_failure = 1'b1; step(1); done_failure = 1'b0;
        step(1);
        chk("status_f", 32'(hex_status), 32'(GF));
        started = 1'b1; step(1); started = 1'b0;
        step(1);
        chk("restart_status", 32'(hex_status), 32'(GD));
        chk("restart_sec", 32'(hex_sec), 32'({G0, G0, G0}));
        step(15);
        chk("restart_sec1", 32'(hex_sec), 32'({G0, G0, 7'b1111001}));
        reset = 1'b1; step(1);
        chk("mid_rst_status", 32'(hex_status), 32'(GB));
        chk("mid_rst_sec", 32'(hex_sec), 32'({G0, G0, G0}));
        chk("mid_rst_view", 32'(view_mode), 32'd0);
        chk("mid_rst_row", 32'(hex_row), 32'(G0));
        reset = 1'b0; step(3);
        chk("idle_status", 32'(hex_status), 32'(GB));
        chk("idle_sec", 32'(hex_sec), 32'({G0, G0, G0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
